// File: rtl/skolem_tt_sweeper.sv
// rtl/skolem_tt_sweeper.sv - exhaustive truth-table sweep and parity check of a combinational skolem netlist
// Optional macro SKF_TT_CAPTURE_EN adds the tt_o truth-table capture port.
module skolem_tt_sweeper #(
    parameter int N_IN    = 6,
    parameter int EXP_INV = 1,
    parameter int SETTLE  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   assign_o,
    input  logic              skf_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     mismatch_cnt,
    output logic [N_IN-1:0]   first_fail
`ifdef SKF_TT_CAPTURE_EN
    ,
    output logic [(1<<N_IN)-1:0] tt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FIN,
        ST_DONE
    } state_t;

    localparam logic [N_IN-1:0] ASSIGN_ONES = '1;
    localparam logic [N_IN-1:0] ASSIGN_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_ONE     = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_MAX     = {1'b1, {N_IN{1'b0}}};
    localparam logic [3:0]      SETTLE_LD   = 4'(SETTLE);
    localparam logic            EXP_BIT     = (EXP_INV != 0);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       exp_bit;
    logic       sample_fail;

    assign exp_bit     = (^assign_o) ^ EXP_BIT;
    assign sample_fail = (skf_i != exp_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            settle_cnt   <= 4'd0;
            assign_o     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
`ifdef SKF_TT_CAPTURE_EN
            tt_o         <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        pass         <= 1'b0;
                        assign_o     <= '0;
                        busy         <= 1'b1;
`ifdef SKF_TT_CAPTURE_EN
                        tt_o         <= '0;
`endif
                        state        <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (SETTLE == 0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= SETTLE_LD;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Leave on the cycle the counter hits zero, so SETTLE idle cycles elapse.
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (sample_fail) begin
                        if (mismatch_cnt != CNT_MAX) begin
                            mismatch_cnt <= mismatch_cnt + CNT_ONE;
                        end
                        if (mismatch_cnt == '0) begin
                            first_fail <= assign_o;
                        end
                    end
`ifdef SKF_TT_CAPTURE_EN
                    tt_o[assign_o] <= skf_i;
`endif
                    if (assign_o == ASSIGN_ONES) begin
                        state <= ST_FIN;
                    end else begin
                        assign_o <= assign_o + ASSIGN_ONE;
                        state    <= ST_DRIVE;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (mismatch_cnt == '0);
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_tt_sweeper.sv
// tb/tb_skolem_tt_sweeper.sv - randomized self-checking bench for skolem_tt_sweeper
module tb_skolem_tt_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start0;
    logic [5:0]  a_main, a_z;
    logic        skf, skf0;
    logic        busy, done, pass, busy0, done0, pass0;
    logic [6:0]  mc, mc0;
    logic [5:0]  ff, ff0;
    logic [63:0] truth;
`ifdef SKF_TT_CAPTURE_EN
    logic [63:0] tt, tt0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign skf  = truth[a_main];
    assign skf0 = truth[a_z];

    skolem_tt_sweeper #(.N_IN(6), .EXP_INV(1), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .assign_o(a_main), .skf_i(skf),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mc), .first_fail(ff)
`ifdef SKF_TT_CAPTURE_EN
        , .tt_o(tt)
`endif
    );

    skolem_tt_sweeper #(.N_IN(6), .EXP_INV(1), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .assign_o(a_z), .skf_i(skf0),
        .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mc0), .first_fail(ff0)
`ifdef SKF_TT_CAPTURE_EN
        , .tt_o(tt0)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Correct netlist column: bit i is the XNOR of the six bits of i.
    function automatic logic [63:0] xnor_column();
        logic [63:0] col;
        for (int i = 0; i < 64; i++) col[i] = ($countones(i) % 2) == 0;
        return col;
    endfunction

    task automatic run_sweep(input string name, input int stray_a, input int stray_b);
        logic [63:0] diff;
        int exp_cnt, exp_first, cyc, done_at, done0_at, ndone, ndone0, bad_steps;
        logic        pass_at_done;
        diff      = truth ^ xnor_column();
        exp_cnt   = $countones(diff);
        exp_first = 0;
        for (int i = 63; i >= 0; i--) if (diff[i]) exp_first = i;
        cyc = 0; done_at = 0; done0_at = 0; ndone = 0; ndone0 = 0; bad_steps = 0;
        pass_at_done = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        start0 = 1'b1;
        while (cyc < 600 && !(done_at != 0 && done0_at != 0)) begin
            @(negedge clk);
            cyc++;
            start  = (cyc == stray_a) || (cyc == stray_b);
            start0 = 1'b0;
            // Each assignment occupies SETTLE+2 cycles; the last one is then held.
            if (cyc <= 258 && int'(a_main) != ((cyc - 1) / 4 > 63 ? 63 : (cyc - 1) / 4)) bad_steps++;
            if (cyc <= 130 && int'(a_z) != ((cyc - 1) / 2 > 63 ? 63 : (cyc - 1) / 2)) bad_steps++;
            if (cyc > 1 && cyc < 258 && !busy) bad_steps++;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = cyc;
                pass_at_done = pass | busy;
            end
            if (done0) begin
                ndone0++;
                if (done0_at == 0) done0_at = cyc;
            end
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
            if (done0) ndone0++;
        end
        check_eq({name, " done_cycle"}, done_at, 258);
        check_eq({name, " done0_cycle"}, done0_at, 130);
        check_eq({name, " done_pulses"}, ndone, 1);
        check_eq({name, " done0_pulses"}, ndone0, 1);
        check_eq({name, " assign_seq"}, bad_steps, 0);
        check_eq({name, " pass_at_done"}, pass_at_done, exp_cnt == 0);
        check_eq({name, " busy_after"}, {busy, busy0}, 2'b00);
        check_eq({name, " pass"}, pass, exp_cnt == 0);
        check_eq({name, " pass0"}, pass0, exp_cnt == 0);
        check_eq({name, " mismatch_cnt"}, mc, exp_cnt);
        check_eq({name, " mismatch_cnt0"}, mc0, exp_cnt);
        check_eq({name, " first_fail"}, ff, exp_first);
        check_eq({name, " first_fail0"}, ff0, exp_first);
`ifdef SKF_TT_CAPTURE_EN
        check_eq({name, " tt_o"}, tt, truth);
        check_eq({name, " tt_o0"}, tt0, truth);
`endif
    endtask

    initial begin
        logic [63:0] mask;
        int          ndone;
        rst_n  = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        truth  = xnor_column();
        repeat (3) @(negedge clk);
        check_eq("reset busy_done_pass", {busy, done, pass}, 3'b000);
        check_eq("reset mismatch_cnt", mc, 0);
        check_eq("reset first_fail", ff, 0);
        check_eq("reset assign_o", a_main, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep("correct", -1, -1);
        truth = ~xnor_column();
        run_sweep("all_fail", -1, -1);
        truth = xnor_column();
        truth[6'h2A] = ~truth[6'h2A];
        run_sweep("fault_2a", -1, -1);
        truth = xnor_column();
        run_sweep("stray_start", 40, 257);

        // Reset dropped mid-sweep must abort silently.
        @(negedge clk);
        start  = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start0 = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset busy_assign", {busy, a_main, busy0, a_z}, 14'd0);
        check_eq("midreset counts", {mc, ff, pass}, 14'd0);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || done0) ndone++;
        end
        rst_n = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (done || done0 || busy) ndone++;
        end
        check_eq("midreset no_done", ndone, 0);
        run_sweep("after_reset", -1, -1);

        for (int it = 0; it < 6; it++) begin
            if (it == 0) mask = 64'h8000_0000_0000_0000;
            else mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            truth = xnor_column() ^ mask;
            run_sweep($sformatf("random%0d", it), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
